// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst-length helper for the arbiter, the bridge and benches.
package ahb_pkg;

    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Number of beats in a burst; undefined-length INCR counts as one beat.
    function automatic logic [CNT_W-1:0] beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return CNT_W'(4);
            HBURST_WRAP8,  HBURST_INCR8:  return CNT_W'(8);
            HBURST_WRAP16, HBURST_INCR16: return CNT_W'(16);
            default:                      return CNT_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin pick: first requester after last_i, wrapping.
module ahb_rr_pick #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [MW-1:0]          last_i,
    output logic [MW-1:0]          winner_c,
    output logic                   valid_c
);

    logic [MW-1:0] idx;
    logic          found;

    // Scan last_i+1 .. last_i+NUM_MASTERS modulo NUM_MASTERS, keep first hit.
    always_comb begin
        winner_c = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = MW'((32'(last_i) + i) % NUM_MASTERS);
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_c = idx;
            end
        end
        valid_c = found;
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter with burst-beat tracking and locked-sequence hold.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned MW             = $clog2(NUM_MASTERS),
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MW-1:0]          grant_idx_q, grant_idx_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          last_q, last_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;

    logic [MW-1:0]          pick_idx;
    logic                   pick_valid;
    logic                   lock_hold;
    logic                   arb_pt;
    logic                   keep;

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_pick (
        .req_i    (hbusreq),
        .last_i   (last_q),
        .winner_c (pick_idx),
        .valid_c  (pick_valid)
    );

    // Remaining beats of the current fixed-length burst.
    always_comb begin
        cnt_d = cnt_q;
        if (hready && htrans == HTRANS_NONSEQ) begin
            cnt_d = beats(hburst) - CNT_W'(1);
        end else if (hready && htrans == HTRANS_SEQ && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Re-arbitrate only at burst/lock boundaries; INCR owner keeps bus while requesting.
    always_comb begin
        lock_hold   = hmastlock_q | hlock[grant_idx_q];
        arb_pt      = hready && !lock_hold && (cnt_d == '0);
        keep        = hbusreq[grant_idx_q] && (hburst == HBURST_INCR) && (htrans != HTRANS_IDLE);
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        if (arb_pt && !keep) begin
            if (pick_valid) begin
                grant_idx_d = pick_idx;
                last_d      = pick_idx;
            end else begin
                grant_idx_d = DEF_IDX;
            end
        end
        grant_d = NUM_MASTERS'(1) << grant_idx_d;
    end

    // Address-phase owner and lock follow the grant on each accepted transfer.
    always_comb begin
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (hready) begin
            hmaster_d   = grant_idx_q;
            hmastlock_d = hlock[grant_idx_q];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            cnt_q       <= '0;
            grant_idx_q <= DEF_IDX;
            grant_q     <= DEF_GRANT;
            last_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            grant_idx_q <= grant_idx_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign hgrant    = grant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector bench for ahb_bus_arbiter (4 masters, default master 0).
module tb_ahb_bus_arbiter;
    import ahb_pkg::*;

    logic       hclk;
    logic       hresetn;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int compares;
    int fails;
    int step;

    typedef struct {
        string      tag;
        logic       rstn;
        logic [3:0] req;
        logic [3:0] lck;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [3:0] exp_grant;
        logic [1:0] exp_master;
        logic       exp_lock;
    } vec_t;

    vec_t vecs[$];

    ahb_bus_arbiter #(
        .NUM_MASTERS    (4),
        .MW             (2),
        .DEFAULT_MASTER (0)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic add(input string tag, input logic rstn, input logic [3:0] req,
                       input logic [3:0] lck, input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                       input logic el);
        vec_t v;
        v.tag = tag; v.rstn = rstn; v.req = req; v.lck = lck; v.tr = tr; v.bu = bu;
        v.rdy = rdy; v.exp_grant = eg; v.exp_master = em; v.exp_lock = el;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock once, then check outputs 1 time unit later.
    task automatic apply(input vec_t v);
        hresetn = v.rstn;
        hbusreq = v.req;
        hlock   = v.lck;
        htrans  = v.tr;
        hburst  = v.bu;
        hready  = v.rdy;
        @(posedge hclk);
        #1;
        step++;
        compares++;
        if (hgrant !== v.exp_grant) begin
            fails++;
            $display("FAIL %s step %0d hgrant: got %b want %b", v.tag, step, hgrant, v.exp_grant);
        end
        compares++;
        if (hmaster !== v.exp_master) begin
            fails++;
            $display("FAIL %s step %0d hmaster: got %0d want %0d", v.tag, step, hmaster, v.exp_master);
        end
        compares++;
        if (hmastlock !== v.exp_lock) begin
            fails++;
            $display("FAIL %s step %0d hmastlock: got %b want %b", v.tag, step, hmastlock, v.exp_lock);
        end
    endtask

    task automatic seq(input string tag, input logic rstn, input logic [3:0] req,
                       input logic [3:0] lck, input logic [1:0] tr, input logic [2:0] bu,
                       input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                       input logic el);
        vec_t v;
        v.tag = tag; v.rstn = rstn; v.req = req; v.lck = lck; v.tr = tr; v.bu = bu;
        v.rdy = rdy; v.exp_grant = eg; v.exp_master = em; v.exp_lock = el;
        apply(v);
    endtask

    initial begin
        compares = 0;
        fails    = 0;
        step     = 0;
        hresetn  = 1'b0;
        hbusreq  = 4'b0000;
        hlock    = 4'b0000;
        htrans   = HTRANS_IDLE;
        hburst   = HBURST_SINGLE;
        hready   = 1'b1;

        // Reset with all requesting, then rotation 1,2,3,0,1 and a mid-sequence reset.
        add("rst0",    1'b0, 4'b1111, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add("rst1",    1'b0, 4'b1111, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add("first",   1'b1, 4'b1111, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add("rot2",    1'b1, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0100, 2'd1, 1'b0);
        add("rot3",    1'b1, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b1000, 2'd2, 1'b0);
        add("rot0",    1'b1, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);
        add("rot1",    1'b1, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add("midrst",  1'b0, 4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        add("park",    1'b1, 4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        // Master 2 alone: single write, then bus parks on master 0.
        add("m2req",   1'b1, 4'b0100, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0100, 2'd0, 1'b0);
        add("m2wr",    1'b1, 4'b0000, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0);
        add("m2done",  1'b1, 4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        // Master 1 INCR4 with master 3 waiting: switch only on the 4th address.
        add("i4req",   1'b1, 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        add("i4ns",    1'b1, 4'b1010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add("i4s1",    1'b1, 4'b1010, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add("i4s2",    1'b1, 4'b1010, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        add("i4s3",    1'b1, 4'b1000, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b1000, 2'd1, 1'b0);
        add("m3wr",    1'b1, 4'b0000, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);

        foreach (vecs[i]) apply(vecs[i]);

        // INCR4 with a two-cycle wait state mid-burst: switch slips by two edges.
        seq("stl_req", 1'b1, 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);
        seq("stl_ns",  1'b1, 4'b1010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        seq("stl_s1",  1'b1, 4'b1010, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        seq("stl_w1",  1'b1, 4'b1010, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 4'b0010, 2'd1, 1'b0);
        seq("stl_w2",  1'b1, 4'b1010, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b0, 4'b0010, 2'd1, 1'b0);
        seq("stl_s2",  1'b1, 4'b1010, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0);
        seq("stl_s3",  1'b1, 4'b1000, 4'b0000, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b1000, 2'd1, 1'b0);
        seq("stl_m3",  1'b1, 4'b0000, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd3, 1'b0);

        // Master 0 locked over two singles; master 1 waits for unlock plus one edge.
        seq("lk_on",   1'b1, 4'b0001, 4'b0001, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b1);
        seq("lk_t1",   1'b1, 4'b0011, 4'b0001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b1);
        seq("lk_t2",   1'b1, 4'b0011, 4'b0001, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b1);
        seq("lk_off",  1'b1, 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd0, 1'b0);
        seq("lk_sw",   1'b1, 4'b0010, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0);

        // Undefined-length INCR owner keeps the bus while it still requests.
        seq("inc_ns",  1'b1, 4'b0110, 4'b0000, HTRANS_NONSEQ, HBURST_INCR,   1'b1, 4'b0010, 2'd1, 1'b0);
        seq("inc_s",   1'b1, 4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR,   1'b1, 4'b0010, 2'd1, 1'b0);
        seq("inc_rel", 1'b1, 4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR,   1'b1, 4'b0100, 2'd1, 1'b0);
        seq("inc_end", 1'b1, 4'b0000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB arbiter that shares the single AHB path into the AHB-to-APB bridge between up to NUM_MASTERS bus masters. Samples bus requests, issues one-hot grants at legal re-arbitration points, tracks fixed-length burst beats and locked sequences so ownership never changes mid-burst, and drives hmaster/hmastlock for the address/data muxes in front of the bridge slave interface.

## Interface
- NUM_MASTERS, 4: number of requesting masters, 2..8.
- MW, $clog2(NUM_MASTERS): width of hmaster.
- DEFAULT_MASTER, 0: master parked on the bus when nobody requests.

- hclk  in  1  bus clock; all logic on rising edge.
- hresetn  in  1  synchronous, active-low reset.
- hbusreq  in  NUM_MASTERS  per-master bus request.
- hlock  in  NUM_MASTERS  per-master locked-transfer request.
- htrans  in  2  muxed transfer type of current address-phase owner.
- hburst  in  3  muxed burst type of current owner.
- hready  in  1  transfer-done from bridge (hr_readyout).
- hgrant  out  NUM_MASTERS  one-hot grant, registered.
- hmaster  out  MW  index of address-phase owner, registered.
- hmastlock  out  1  current address phase is locked, registered.

## Operation
- Encodings: htrans IDLE=0, BUSY=1, NONSEQ=2, SEQ=3; hburst SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7.
- Beat counter cnt (5 bits): on hready && htrans==NONSEQ load beats(hburst)-1 (3/7/15 for 4/8/16-beat bursts, 0 for SINGLE/INCR); on hready && htrans==SEQ && cnt!=0 decrement; otherwise hold. cnt_nxt = value after this edge.
- lock_hold = hmastlock | hlock[grant_idx].
- Arbitration point arb_pt = hready && !lock_hold && cnt_nxt==0.
- Keep rule at arb_pt: if hbusreq[grant_idx] && hburst==INCR && htrans!=IDLE, grant unchanged (undefined-length burst owns bus until it drops request).
- Otherwise round-robin: search hbusreq starting at last_idx+1 modulo NUM_MASTERS; first hit wins; last_idx <= winner. No request: grant DEFAULT_MASTER, last_idx unchanged.
- hmaster <= grant_idx and hmastlock <= hlock[grant_idx] on every edge with hready=1; hold when hready=0.
- Invalid hburst/htrans combinations not checked; SEQ with cnt==0 leaves cnt at 0.

## Timing
- Reset (hresetn=0 at edge): hgrant=one-hot(DEFAULT_MASTER), hmaster=DEFAULT_MASTER, hmastlock=0, cnt=0, last_idx=DEFAULT_MASTER. Reset mid-burst aborts immediately, no completion.
- Grant latency: request sampled at edge E with arb_pt -> hgrant valid after E; hmaster follows at first later edge with hready=1 (new master's NONSEQ address phase).
- Fixed burst INCR4 owner: no regrant at NONSEQ or first two SEQ edges; earliest regrant at edge accepting the 4th address (cnt 1->0).
- hready=0 freezes grant, hmaster, hmastlock, cnt.
- Lock: regrant blocked while hlock of grantee asserted and for the following hready edge while hmastlock=1.
- Simultaneous requests from all masters: strict rotation, each granted once per NUM_MASTERS arb points.
- Grantee dropping hbusreq with no other requester: grant parks on DEFAULT_MASTER at next arb_pt.

## Structure
- Shared package ahb_pkg: htrans/hburst localparams and function beats(hburst) returning burst length; reused by bridge and bench.
- Sub-module ahb_rr_pick: combinational round-robin pick (req vector, last_idx -> winner index, any-valid flag). Top holds cnt, grant, last_idx, hmaster, hmastlock registers.

## Test plan
- Reset with hbusreq=4'b1111 held -> hgrant=4'b0001, hmaster=0, hmastlock=0 until first edge after hresetn=1; first grant then goes to master 1.
- Master 2 alone: single write NONSEQ SINGLE to 32'h8400_0000 -> hgrant=4'b0100 one edge after request, hmaster=2 at next hready edge.
- Master 1 INCR4 write (NONSEQ then 3 SEQ), master 3 requesting throughout -> hgrant stays 4'b0010 for 3 edges, switches to 4'b1000 at edge accepting 4th address.
- Same INCR4 with hready=0 for 2 cycles mid-burst -> grant and cnt frozen; switch delayed exactly 2 cycles.
- Master 0 hlock=1 over two SINGLE transfers, master 1 requesting -> hmastlock=1, no regrant until hlock drops plus one hready edge.
- All four requesting, SINGLE transfers, hready=1 -> grants cycle 1,2,3,0,1; hresetn=0 mid-sequence -> hgrant=4'b0001, cnt=0 next edge.
